// File: rtl/op_issue_queue_if.sv
// Decoded G-code op type and the parser/processor handshake bundle for op_issue_queue.
// The queue uses the slave modport; the parser/ProcessorTop side uses master.
package op_issue_pkg;
   typedef struct packed {
      logic [7:0]         cmd;
      logic signed [15:0] arg_1;
      logic signed [15:0] arg_2;
      logic signed [15:0] arg_3;
      logic signed [15:0] arg_4;
      logic [3:0]         flags;
   } op_st;
endpackage

interface op_issue_queue_if #(
   parameter int OP_BITS = $bits(op_issue_pkg::op_st)
);
   logic [OP_BITS-1:0] in_op;
   logic               in_valid;
   logic               in_rdy;
   logic [OP_BITS-1:0] proc_op;
   logic               proc_trigger;
   logic               proc_rdy;

   modport slave (
      input  in_op, in_valid, proc_rdy,
      output in_rdy, proc_op, proc_trigger
   );

   modport master (
      output in_op, in_valid, proc_rdy,
      input  in_rdy, proc_op, proc_trigger
   );
endinterface

// File: rtl/op_issue_queue.sv
// Circular op buffer between the G-code parser and ProcessorTop; issues one op at a
// time over the trigger/rdy handshake.
//
// state | meaning
// IDLE  | waiting for a queued op and proc_rdy=1
// ISSUE | proc_trigger high, proc_op held until the processor drops rdy
// WAIT  | op accepted, waiting for the processor to raise rdy again
module op_issue_queue #(
   parameter int DEPTH   = 4,
   parameter int OP_BITS = $bits(op_issue_pkg::op_st)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clk_en,
   input  logic                   flush,
   op_issue_queue_if.slave        bus,
   output logic [$clog2(DEPTH):0] level,
   output logic                   busy
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t             state;
   logic [OP_BITS-1:0] mem [DEPTH];
   logic [PW-1:0]      wr_ptr;
   logic [PW-1:0]      rd_ptr;
   logic               full;
   logic               empty;
   logic               push;
   logic               pop;

   assign full  = (level == LW'(DEPTH));
   assign empty = (level == '0);

   // Capacity is judged on the registered level, so a pop frees its slot one cycle later.
   assign bus.in_rdy = !full && !flush;
   assign push       = clk_en && bus.in_valid && bus.in_rdy;
   assign pop        = clk_en && (state == ISSUE) && !bus.proc_rdy && !empty;

   assign busy = (state != IDLE) || !empty;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= bus.in_op;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (clk_en) begin
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
         end else begin
            if (push) begin
               wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
               rd_ptr <= rd_ptr + PW'(1);
            end
            level <= level + LW'(push) - LW'(pop);
         end
      end
   end

   // Flush leaves the handshake alone: an op already in ISSUE finishes from proc_op.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state            <= IDLE;
         bus.proc_trigger <= 1'b0;
         bus.proc_op      <= '0;
      end else if (clk_en) begin
         case (state)
            IDLE: begin
               if (!empty && bus.proc_rdy) begin
                  bus.proc_op      <= mem[rd_ptr];
                  bus.proc_trigger <= 1'b1;
                  state            <= ISSUE;
               end
            end
            ISSUE: begin
               if (!bus.proc_rdy) begin
                  bus.proc_trigger <= 1'b0;
                  state            <= WAIT;
               end
            end
            WAIT: begin
               if (bus.proc_rdy) begin
                  state <= IDLE;
               end
            end
            default: begin
               bus.proc_trigger <= 1'b0;
               state            <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_op_issue_queue.sv
// Directed bench for op_issue_queue: single op, burst/full, streamed handshakes,
// wrap-around, flush during ISSUE, clk_en gating and async reset.
module tb_op_issue_queue;
   import op_issue_pkg::*;

   localparam int DEPTH = 4;
   localparam int OPB   = $bits(op_st);

   logic       clk    = 1'b0;
   logic       reset  = 1'b0;
   logic       clk_en = 1'b1;
   logic       flush  = 1'b0;
   logic [2:0] level;
   logic       busy;

   int   n_vec = 0;
   int   n_err = 0;
   op_st sb[$];

   op_issue_queue_if #(.OP_BITS(OPB)) bus ();

   op_issue_queue #(.DEPTH(DEPTH), .OP_BITS(OPB)) dut (
      .clk    (clk),
      .reset  (reset),
      .clk_en (clk_en),
      .flush  (flush),
      .bus    (bus),
      .level  (level),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic op_st mk(input int c, input int a1, input int a2,
                               input int a3, input int a4, input int f);
      op_st o;
      o.cmd   = 8'(c);
      o.arg_1 = 16'(a1);
      o.arg_2 = 16'(a2);
      o.arg_3 = 16'(a3);
      o.arg_4 = 16'(a4);
      o.flags = 4'(f);
      return o;
   endfunction

   task automatic push_now(input op_st o);
      bus.in_op    = o;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_trig();
      int k = 0;
      while (bus.proc_trigger !== 1'b1 && k < 60) begin
         tick();
         k++;
      end
      if (k == 60) chk("trig_timeout", bus.proc_trigger, 1);
   endtask

   // ProcessorTop model: accept after one held cycle, stay busy for 'low' cycles.
   task automatic serve(input op_st exp, input int low);
      int viol = 0;
      wait_trig();
      chk("issue_op", bus.proc_op, exp);
      tick();
      chk("trig_held", bus.proc_trigger, 1);
      chk("op_held", bus.proc_op, exp);
      bus.proc_rdy = 1'b0;
      tick();
      chk("trig_drop", bus.proc_trigger, 0);
      repeat (low) begin
         tick();
         if (bus.proc_trigger) viol++;
      end
      chk("trig_while_low", viol, 0);
      chk("op_stable_wait", bus.proc_op, exp);
      bus.proc_rdy = 1'b1;
   endtask

   task automatic stream(input int n, input int low, input int base);
      fork
         begin
            for (int i = 0; i < n; i++) begin
               op_st o;
               int   k;
               logic acc;
               o = mk(1, base + i * 10, -i * 5, i, 200 - i, i % 16);
               bus.in_op    = o;
               bus.in_valid = 1'b1;
               k   = 0;
               acc = 1'b0;
               while (!acc && k < 300) begin
                  acc = bus.in_rdy;
                  tick();
                  k++;
               end
               if (acc) sb.push_back(o);
               else chk("push_timeout", bus.in_rdy, 1);
            end
            bus.in_valid = 1'b0;
         end
         begin
            for (int j = 0; j < n; j++) begin
               op_st e;
               wait_trig();
               e = (sb.size() > 0) ? sb.pop_front() : '0;
               serve(e, low);
            end
         end
      join
   endtask

   initial begin
      op_st g00, b0, b1, b2, b3, b4, fa, fb, fc, fe, x, y, z;
      int   viol;
      bus.in_op    = '0;
      bus.in_valid = 1'b0;
      bus.proc_rdy = 1'b1;

      #1;
      chk("rst_trig", bus.proc_trigger, 0);
      chk("rst_level", level, 0);
      chk("rst_op", bus.proc_op, 0);
      chk("rst_busy", busy, 0);
      tick();
      tick();
      reset = 1'b1;
      #1;
      chk("rst_in_rdy", bus.in_rdy, 1);

      // single op: trigger two cycles after push
      g00 = mk(0, 100, 100, 0, 0, 0);
      push_now(g00);
      chk("s_level1", level, 1);
      chk("s_trig_n1", bus.proc_trigger, 0);
      tick();
      chk("s_trig_n2", bus.proc_trigger, 1);
      chk("s_op", bus.proc_op, g00);
      bus.proc_rdy = 1'b0;
      tick();
      chk("s_trig_drop", bus.proc_trigger, 0);
      chk("s_level0", level, 0);
      bus.proc_rdy = 1'b1;
      tick();
      chk("s_busy", busy, 0);

      // burst into a full queue with the processor not ready
      b0 = mk(90, 0, 0, 0, 0, 0);
      b1 = mk(2, 100, 100, 0, -20, 3);
      b2 = mk(0, 80, 100, 0, 0, 0);
      b3 = mk(1, 120, 100, 0, 0, 0);
      b4 = mk(1, 120, 60, 0, 0, 0);
      bus.proc_rdy = 1'b0;
      push_now(b0);
      push_now(b1);
      push_now(b2);
      push_now(b3);
      chk("b_level_full", level, 4);
      chk("b_in_rdy_full", bus.in_rdy, 0);
      chk("b_no_trig_rdy_low", bus.proc_trigger, 0);
      bus.in_op    = b4;
      bus.in_valid = 1'b1;
      tick();
      chk("b_5th_rejected", level, 4);
      bus.proc_rdy = 1'b1;
      tick();
      chk("b_trig0", bus.proc_trigger, 1);
      chk("b_op0", bus.proc_op, b0);
      bus.proc_rdy = 1'b0;
      tick();
      chk("b_pop_level", level, 3);
      chk("b_in_rdy_after_pop", bus.in_rdy, 1);
      tick();
      bus.in_valid = 1'b0;
      chk("b_5th_accepted", level, 4);
      bus.proc_rdy = 1'b1;
      tick();
      serve(b1, 2);
      serve(b2, 2);
      serve(b3, 2);
      serve(b4, 2);
      tick();
      chk("b_drained", level, 0);
      chk("b_busy", busy, 0);

      // streamed handshake: 10-cycle busy processor, then fast wrap-around
      stream(12, 10, 1000);
      stream(9, 1, 3000);
      tick();
      chk("st_level", level, 0);

      // flush during ISSUE with queued ops and a same-cycle push
      fa = mk(1, 10, 20, 0, 0, 1);
      fb = mk(1, 30, 40, 0, 0, 2);
      fc = mk(1, 50, 60, 0, 0, 3);
      fe = mk(1, 70, 80, 0, 0, 4);
      bus.proc_rdy = 1'b0;
      push_now(fa);
      push_now(fb);
      push_now(fc);
      chk("f_level3", level, 3);
      bus.proc_rdy = 1'b1;
      tick();
      chk("f_trig", bus.proc_trigger, 1);
      chk("f_op", bus.proc_op, fa);
      flush        = 1'b1;
      bus.in_op    = fe;
      bus.in_valid = 1'b1;
      #1;
      chk("f_in_rdy_flush", bus.in_rdy, 0);
      tick();
      flush        = 1'b0;
      bus.in_valid = 1'b0;
      chk("f_level0", level, 0);
      chk("f_trig_kept", bus.proc_trigger, 1);
      chk("f_op_kept", bus.proc_op, fa);
      bus.proc_rdy = 1'b0;
      tick();
      chk("f_trig_drop", bus.proc_trigger, 0);
      chk("f_no_underflow", level, 0);
      bus.proc_rdy = 1'b1;
      viol = 0;
      repeat (10) begin
         tick();
         if (bus.proc_trigger) viol++;
      end
      chk("f_no_more_trig", viol, 0);
      chk("f_busy", busy, 0);

      // clk_en gating
      clk_en = 1'b0;
      flush  = 1'b1;
      #1;
      chk("e_in_rdy_flush", bus.in_rdy, 0);
      flush = 1'b0;
      x = mk(1, 5, 6, 7, 8, 9);
      bus.in_op    = x;
      bus.in_valid = 1'b1;
      tick();
      chk("e_push_frozen", level, 0);
      clk_en = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      chk("e_push_en", level, 1);
      clk_en = 1'b0;
      tick();
      tick();
      chk("e_issue_frozen", bus.proc_trigger, 0);
      clk_en = 1'b1;
      tick();
      chk("e_issue_en", bus.proc_trigger, 1);
      chk("e_op", bus.proc_op, x);
      bus.proc_rdy = 1'b0;
      clk_en       = 1'b0;
      tick();
      tick();
      chk("e_trig_frozen", bus.proc_trigger, 1);
      chk("e_level_frozen", level, 1);
      clk_en = 1'b1;
      tick();
      chk("e_trig_drop", bus.proc_trigger, 0);
      chk("e_pop", level, 0);
      y = mk(3, 1, 2, 3, 4, 5);
      push_now(y);
      chk("e_level_wait", level, 1);

      // async reset mid-WAIT, then mid-ISSUE
      #2 reset = 1'b0;
      #1;
      chk("r_level", level, 0);
      chk("r_trig", bus.proc_trigger, 0);
      chk("r_busy", busy, 0);
      #2 reset = 1'b1;
      bus.proc_rdy = 1'b1;
      tick();
      z = mk(1, 9, 9, 9, 9, 9);
      push_now(z);
      tick();
      chk("r2_trig_before", bus.proc_trigger, 1);
      #2 reset = 1'b0;
      #1;
      chk("r2_trig", bus.proc_trigger, 0);
      chk("r2_op", bus.proc_op, 0);
      chk("r2_level", level, 0);
      #2 reset = 1'b1;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
